hi_lo_muldiv_unit: RTL and testbench

HI_LO_MULDIV_UNIT -- requirements
Module: hi_lo_muldiv_unit

---
 rtl/hi_lo_muldiv_unit.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_hi_lo_muldiv_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hi_lo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// hi_lo_muldiv_unit
//
// HI/LO multiply/divide unit for a MIPS-style integer pipeline. Owns the
// architectural HI and LO registers. It runs mult/multu/div/divu as
// multi-cycle operations and handles mthi/mtlo moves.
//
// Ports
//   clk                clock; all state updates on the rising edge
//   reset              synchronous, active-high reset
//   HI_register_write  decode strobe: mult/multu/div/divu/mthi
//   LO_register_write  decode strobe: mult/multu/div/divu/mtlo
//   ALU_function[5:0]  funct field selecting the operation
//   operand_a[31:0]    rs: dividend / multiplicand / move source
//   operand_b[31:0]    rt: divisor / multiplier
//   HI[31:0]           architectural HI (remainder / product high word)
//   LO[31:0]           architectural LO (quotient / product low word)
//   busy               high while an operation is in flight
//
// Parameter
//   HILO_RESET         value loaded into HI and LO on reset
//
// Build option
//   FAST_MULT_EN       when defined, mult/multu form the 64-bit product in a
//                      single step and bypass the iterative RUN state.
//                      Division is always iterative.
//
// Timing (iterative path)
//   E0       request accepted; operands latched; state moves to RUN.
//   E1..E32  one algorithm step per edge.
//   E33      sign and divide-by-zero fixup into the result registers.
//   E34      HI/LO written; busy falls.
// ---------------------------------------------------------------------------
module hi_lo_muldiv_unit #(
  parameter logic [31:0] HILO_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HI_register_write,
  input  logic        LO_register_write,
  input  logic [5:0]  ALU_function,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_quo_q, neg_quo_d;     // negate quotient / product
  logic        neg_rem_q, neg_rem_d;     // negate remainder (dividend sign)
  logic        dbz_q, dbz_d;             // divisor was zero
  logic [31:0] a_raw_q, a_raw_d;         // unmodified operand_a, for div-by-zero
  logic [31:0] dvsr_q, dvsr_d;           // |divisor| or |multiplicand|
  logic [31:0] acc_hi_q, acc_hi_d;       // partial remainder / product high
  logic [31:0] acc_lo_q, acc_lo_d;       // dividend->quotient / multiplier->product low
  logic        fin_phase_q, fin_phase_d; // 0: fixup edge, 1: writeback edge
  logic [31:0] res_hi_q, res_hi_d;
  logic [31:0] res_lo_q, res_lo_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  logic is_mul_fn, is_div_fn, is_signed_fn;
  logic start_req, mthi_req, mtlo_req;

  assign is_mul_fn    = (ALU_function == FN_MULT) || (ALU_function == FN_MULTU);
  assign is_div_fn    = (ALU_function == FN_DIV)  || (ALU_function == FN_DIVU);
  assign is_signed_fn = (ALU_function == FN_MULT) || (ALU_function == FN_DIV);

  // An arithmetic op needs both strobes. A move needs exactly its own
  // strobe and the matching funct code. Any other funct code is ignored.
  assign start_req = HI_register_write && LO_register_write && (is_mul_fn || is_div_fn);
  assign mthi_req  = HI_register_write && !LO_register_write && (ALU_function == FN_MTHI);
  assign mtlo_req  = LO_register_write && !HI_register_write && (ALU_function == FN_MTLO);

  // Magnitudes for the signed ops. |0x8000_0000| wraps to 0x8000_0000,
  // which is still the correct unsigned magnitude.
  logic [31:0] abs_a, abs_b;
  assign abs_a = (is_signed_fn && operand_a[31]) ? (~operand_a + 32'd1) : operand_a;
  assign abs_b = (is_signed_fn && operand_b[31]) ? (~operand_b + 32'd1) : operand_b;

  // -------------------------------------------------------------------------
  // Iteration datapath
  // -------------------------------------------------------------------------
  // Restoring division: shift the next dividend bit into the partial
  // remainder, then try to subtract the divisor.
  logic [32:0] div_shift;
  logic [31:0] div_diff;
  logic        div_ok;
  logic [31:0] div_rem_next;

  assign div_shift    = {acc_hi_q, acc_lo_q[31]};
  assign div_ok       = (div_shift >= {1'b0, dvsr_q});
  // When the subtraction succeeds the true difference is below the divisor,
  // so 32-bit wraparound arithmetic gives the exact result.
  assign div_diff     = div_shift[31:0] - dvsr_q;
  assign div_rem_next = div_ok ? div_diff : div_shift[31:0];

  // Shift-add multiply: conditionally add the multiplicand into the high
  // half, then shift {carry, high, low} right by one bit.
  logic [32:0] mul_sum;
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, dvsr_q} : 33'd0);

  // -------------------------------------------------------------------------
  // Result fixup (sign correction and divide-by-zero override)
  // -------------------------------------------------------------------------
  logic [63:0] prod_mag, prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic [31:0] fix_hi, fix_lo;

`ifdef FAST_MULT_EN
  logic [63:0] fast_prod;
  assign fast_prod = 64'(dvsr_q) * 64'(acc_lo_q);
`endif

  always_comb begin
`ifdef FAST_MULT_EN
    prod_mag = fast_prod;
`else
    prod_mag = {acc_hi_q, acc_lo_q};
`endif
    prod_fix = neg_quo_q ? (~prod_mag + 64'd1) : prod_mag;
    quo_fix  = neg_quo_q ? (~acc_lo_q + 32'd1) : acc_lo_q;
    rem_fix  = neg_rem_q ? (~acc_hi_q + 32'd1) : acc_hi_q;

    if (is_div_q) begin
      if (dbz_q) begin
        // Divide by zero: LO is all ones and HI is the original dividend,
        // whatever the signedness.
        fix_hi = a_raw_q;
        fix_lo = 32'hFFFF_FFFF;
      end else begin
        fix_hi = rem_fix;
        fix_lo = quo_fix;
      end
    end else begin
      fix_hi = prod_fix[63:32];
      fix_lo = prod_fix[31:0];
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    dbz_d       = dbz_q;
    a_raw_d     = a_raw_q;
    dvsr_d      = dvsr_q;
    acc_hi_d    = acc_hi_q;
    acc_lo_d    = acc_lo_q;
    fin_phase_d = fin_phase_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    hi_d        = hi_q;
    lo_d        = lo_q;

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          state_d     = S_RUN;
          cnt_d       = 5'd0;
          is_div_d    = is_div_fn;
          neg_quo_d   = is_signed_fn && (operand_a[31] ^ operand_b[31]);
          neg_rem_d   = is_signed_fn && operand_a[31];
          dbz_d       = (operand_b == 32'd0);
          a_raw_d     = operand_a;
          acc_hi_d    = 32'd0;
          fin_phase_d = 1'b0;
          if (is_div_fn) begin
            acc_lo_d = abs_a;   // dividend bits shift out the top
            dvsr_d   = abs_b;
          end else begin
            acc_lo_d = abs_b;   // multiplier bits shift out the bottom
            dvsr_d   = abs_a;
          end
`ifdef FAST_MULT_EN
          if (!is_div_fn) begin
            state_d = S_FINISH;
          end
`endif
        end else begin
          if (mthi_req) begin
            hi_d = operand_a;
          end
          if (mtlo_req) begin
            lo_d = operand_a;
          end
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          acc_hi_d = div_rem_next;
          acc_lo_d = {acc_lo_q[30:0], div_ok};
        end else begin
          acc_hi_d = mul_sum[32:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        if (!fin_phase_q) begin
          res_hi_d    = fix_hi;
          res_lo_d    = fix_lo;
          fin_phase_d = 1'b1;
        end else begin
          hi_d        = res_hi_q;
          lo_d        = res_lo_q;
          fin_phase_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      is_div_q    <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
      a_raw_q     <= 32'd0;
      dvsr_q      <= 32'd0;
      acc_hi_q    <= 32'd0;
      acc_lo_q    <= 32'd0;
      fin_phase_q <= 1'b0;
      res_hi_q    <= 32'd0;
      res_lo_q    <= 32'd0;
      hi_q        <= HILO_RESET;
      lo_q        <= HILO_RESET;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      dbz_q       <= dbz_d;
      a_raw_q     <= a_raw_d;
      dvsr_q      <= dvsr_d;
      acc_hi_q    <= acc_hi_d;
      acc_lo_q    <= acc_lo_d;
      fin_phase_q <= fin_phase_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_hi_lo_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_hi_lo_muldiv_unit
//
// Self-checking bench for hi_lo_muldiv_unit. An arithmetic reference model
// built on 64-bit integer math predicts HI/LO. The bench then covers these
// cases:
//   - directed vectors
//   - moves
//   - ignored requests
//   - reset during an operation
//   - a randomized operation mix
// ---------------------------------------------------------------------------
module tb_hi_lo_muldiv_unit;

  localparam logic [31:0] RST_VAL = 32'h0BAD_F00D;

  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        reset;
  logic        hi_w, lo_w;
  logic [5:0]  fn;
  logic [31:0] op_a, op_b;
  logic [31:0] hi_o, lo_o;
  logic        busy;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Architectural HI/LO expected by the model.
  logic [31:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  hi_lo_muldiv_unit #(.HILO_RESET(RST_VAL)) dut (
    .clk               (clk),
    .reset             (reset),
    .HI_register_write (hi_w),
    .LO_register_write (lo_w),
    .ALU_function      (fn),
    .operand_a         (op_a),
    .operand_b         (op_b),
    .HI                (hi_o),
    .LO                (lo_o),
    .busy              (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the operand values.
  function automatic void ref_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] rh, output logic [31:0] rl);
    longint      sa, sb, sr;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = 32'd0;
    rl = 32'd0;
    case (f)
      FN_MULT: begin
        sr = sa * sb;
        u  = sr;
        rh = u[63:32];
        rl = u[31:0];
      end
      FN_MULTU: begin
        u  = {32'd0, a} * {32'd0, b};
        rh = u[63:32];
        rl = u[31:0];
      end
      FN_DIV: begin
        if (b == 32'd0) begin
          rh = a;
          rl = 32'hFFFF_FFFF;
        end else begin
          sr = sa / sb;
          u  = sr;
          rl = u[31:0];
          sr = sa % sb;
          u  = sr;
          rh = u[31:0];
        end
      end
      FN_DIVU: begin
        if (b == 32'd0) begin
          rh = a;
          rl = 32'hFFFF_FFFF;
        end else begin
          rl = a / b;
          rh = a % b;
        end
      end
      default: begin
        rh = 32'd0;
        rl = 32'd0;
      end
    endcase
  endfunction

  // Issue one arithmetic op and follow it to completion.
  // intf=1 drives an mtlo and then a fresh divu while the op is running;
  // the unit must ignore both.
  task automatic do_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit intf);
    logic [31:0] mh, ml;
    int          n;
    int          exp_lat;
    bit          done;
    ref_op(f, a, b, mh, ml);
    exp_lat = 34;
`ifdef FAST_MULT_EN
    if (f == FN_MULT || f == FN_MULTU) exp_lat = 2;
`endif
    @(negedge clk);
    hi_w = 1'b1; lo_w = 1'b1; fn = f; op_a = a; op_b = b;
    @(posedge clk);                     // E0
    @(negedge clk);
    hi_w = 1'b0; lo_w = 1'b0; op_a = $urandom; op_b = $urandom;
    check_val("busy_after_start", 32'(busy), 32'd1);
    n = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      if (intf && n == 4) begin lo_w = 1'b1; fn = FN_MTLO; op_a = $urandom; end
      if (intf && n == 5) begin hi_w = 1'b1; lo_w = 1'b1; fn = FN_DIVU; end
      if (intf && n == 6) begin hi_w = 1'b0; lo_w = 1'b0; end
      @(negedge clk);
      n++;
      if (n == exp_lat - 1) begin
        check_val("hi_held_before_write", hi_o, exp_hi);
        check_val("lo_held_before_write", lo_o, exp_lo);
      end
      if (!busy) done = 1'b1;
    end
    hi_w = 1'b0; lo_w = 1'b0;
    check_val("latency", 32'(n), 32'(exp_lat));
    check_val("hi_result", hi_o, mh);
    check_val("lo_result", lo_o, ml);
    exp_hi = mh;
    exp_lo = ml;
    $display("txn fn=%b a=%08h b=%08h intf=%0d -> HI=%08h LO=%08h cycles=%0d",
             f, a, b, intf, hi_o, lo_o, n);
  endtask

  // Drive one single-strobe move or ignored request for one edge.
  task automatic single_edge(input logic hw, input logic lw, input logic [5:0] f, input logic [31:0] a);
    @(negedge clk);
    hi_w = hw; lo_w = lw; fn = f; op_a = a; op_b = $urandom;
    @(posedge clk);
    @(negedge clk);
    hi_w = 1'b0; lo_w = 1'b0;
  endtask

  logic [5:0]  fn_tab [4] = '{FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
  logic [31:0] ra, rb;

  initial begin
    reset = 1'b1; hi_w = 1'b0; lo_w = 1'b0; fn = 6'd0; op_a = 32'd0; op_b = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_val("reset_hi", hi_o, RST_VAL);
    check_val("reset_lo", lo_o, RST_VAL);
    check_val("reset_busy", 32'(busy), 32'd0);
    exp_hi = RST_VAL;
    exp_lo = RST_VAL;

    // Directed vectors.
    do_op(FN_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    check_val("mult_hi_const", hi_o, 32'hFFFF_FFFF);
    check_val("mult_lo_const", lo_o, 32'hFFFF_FFFA);
    do_op(FN_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0);
    check_val("multu_hi_const", hi_o, 32'h0000_0002);
    check_val("multu_lo_const", lo_o, 32'hFFFF_FFFA);
    do_op(FN_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    check_val("div_lo_const", lo_o, 32'hFFFF_FFFD);
    check_val("div_hi_const", hi_o, 32'hFFFF_FFFF);
    do_op(FN_DIVU, 32'd7, 32'd0, 1'b0);
    check_val("divu0_lo_const", lo_o, 32'hFFFF_FFFF);
    check_val("divu0_hi_const", hi_o, 32'd7);
    do_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_val("divovf_lo_const", lo_o, 32'h8000_0000);
    check_val("divovf_hi_const", hi_o, 32'd0);
    do_op(FN_DIV, 32'hFFFF_FFF9, 32'd0, 1'b0);
    check_val("div0_hi_const", hi_o, 32'hFFFF_FFF9);

    // mthi while idle.
    single_edge(1'b1, 1'b0, FN_MTHI, 32'h1234_5678);
    check_val("mthi_hi", hi_o, 32'h1234_5678);
    check_val("mthi_lo_kept", lo_o, exp_lo);
    check_val("mthi_busy", 32'(busy), 32'd0);
    exp_hi = 32'h1234_5678;
    // mtlo while idle.
    single_edge(1'b0, 1'b1, FN_MTLO, 32'hCAFE_0001);
    check_val("mtlo_lo", lo_o, 32'hCAFE_0001);
    check_val("mtlo_hi_kept", hi_o, exp_hi);
    exp_lo = 32'hCAFE_0001;
    // Unsupported funct code with both strobes.
    single_edge(1'b1, 1'b1, 6'b100000, 32'hDEAD_BEEF);
    check_val("unsup_busy", 32'(busy), 32'd0);
    check_val("unsup_hi_kept", hi_o, exp_hi);
    check_val("unsup_lo_kept", lo_o, exp_lo);

    // mtlo (and a new divu) during divu: both ignored.
    do_op(FN_DIVU, 32'd100, 32'd7, 1'b1);
    check_val("divu_intf_lo_const", lo_o, 32'd14);

    // Reset during a div: nothing from it reaches HI/LO.
    @(negedge clk);
    hi_w = 1'b1; lo_w = 1'b1; fn = FN_DIV; op_a = 32'h7654_3210; op_b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    hi_w = 1'b0; lo_w = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_val("abort_hi", hi_o, RST_VAL);
    check_val("abort_lo", lo_o, RST_VAL);
    check_val("abort_busy", 32'(busy), 32'd0);
    exp_hi = RST_VAL;
    exp_lo = RST_VAL;
    repeat (30) @(negedge clk);
    check_val("abort_no_late_write", hi_o, RST_VAL);
    do_op(FN_DIVU, 32'd100, 32'd7, 1'b0);
    check_val("post_reset_lo_const", lo_o, 32'd14);
    check_val("post_reset_hi_const", hi_o, 32'd2);

    // Randomized mix with edge-case operand biasing.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: ra = 32'h8000_0000;
        2: rb = 32'($urandom_range(1, 15));
        3: begin ra = 32'($urandom_range(0, 1000)); rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      do_op(fn_tab[$urandom_range(0, 3)], ra, rb, bit'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
